dkong_sound_cmd_seq: RTL
========================

DKONG_SOUND_CMD_SEQ -- requirements
Module: dkong_sound_cmd_seq

Interface
Parameters:
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of queued background commands (power of two, 2..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 65535, masterclk cycles to wait for the sound CPU acknowledge before aborting.
Ports:
REQ-003 masterclk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cpu_wr  input  1  one-cycle write strobe from the main-CPU decode.
REQ-006 io_sel  input  2  write target: 00 = bg (7C00), 01 = sfx (7D0x), 10 = irq (7D80), 11 = subsfx (7C8x).
REQ-007 io_idx  input  3  sfx bit index for io_sel = 01.
REQ-008 cpu_din  input  8  write data.
REQ-009 snd_ack  input  1  acknowledge from the sound CPU, active-high.
REQ-010 bg_port  output  5  background command presented to the sound CPU.
REQ-011 sfx_port  output  8  sfx trigger latch.
REQ-012 subsfx_port  output  1  sub-sfx latch.
REQ-013 audio_irq_n  output  1  interrupt to the sound CPU, active-low.
REQ-014 fifo_full  output  1  high when the queue holds FIFO_DEPTH entries.
REQ-015 busy  output  1  high whenever the FSM is not IDLE or the queue is non-empty.
REQ-016 err_flags  output  2  sticky flags: [0] overflow, [1] ack timeout.

Function
REQ-017 An sfx write SHALL set sfx_port[io_idx] to cpu_din[0] on the next edge; all other bits are unchanged.
REQ-018 A subsfx write SHALL set subsfx_port to cpu_din[0] on the next edge.
REQ-019 A bg write SHALL push cpu_din[4:0] into the FIFO; a push while full SHALL drop the data and set err_flags[0].
REQ-020 An irq write with cpu_din[0] = 1 SHALL push the current bg_port value, a resend; with cpu_din[0] = 0 it is ignored.
REQ-021 FSM states: IDLE, LOAD, ASSERT, WAIT_ACK, WAIT_REL.
REQ-022 IDLE -> LOAD when the FIFO is non-empty; LOAD pops the head into bg_port (1 cycle).
REQ-023 LOAD -> ASSERT; ASSERT drives audio_irq_n = 0 and clears the timeout counter, then -> WAIT_ACK.
REQ-024 WAIT_ACK keeps audio_irq_n = 0; on snd_ack = 1 it drives audio_irq_n = 1 and -> WAIT_REL.
REQ-025 WAIT_REL -> IDLE when snd_ack = 0; audio_irq_n stays 1.
REQ-026 Latency from a bg write into an empty FIFO with the FSM in IDLE to audio_irq_n falling SHALL be 3 cycles.
REQ-027 bg_port SHALL remain stable from LOAD until the next LOAD.
REQ-028 A simultaneous push and pop SHALL both take effect; the count is unchanged and fifo_full is unaffected.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count width is clog2(FIFO_DEPTH)+1.
REQ-030 snd_ack = 1 while in IDLE or LOAD SHALL be ignored.
REQ-031 err_flags SHALL be cleared only by reset.

Reset
REQ-032 Asserting rst_n low SHALL immediately force IDLE, empty FIFO, bg_port = 0, sfx_port = 0, subsfx_port = 0, audio_irq_n = 1, err_flags = 0, busy = 0, fifo_full = 0.
REQ-033 Reset mid-handshake SHALL abandon the in-flight command and release audio_irq_n without waiting for snd_ack.

Configuration
REQ-034 Macro DKONG_SND_ACK_TIMEOUT_EN defined: in WAIT_ACK, once the counter reaches ACK_TIMEOUT without snd_ack, the FSM SHALL drive audio_irq_n = 1, set err_flags[1] and go to IDLE; the command is discarded.
REQ-035 Macro not defined: WAIT_ACK SHALL wait indefinitely, no counter is built, and err_flags[1] is tied to 0.

Verification
REQ-036 Reset, then bg write 0x15 with snd_ack tied low -> bg_port = 0x15 and audio_irq_n = 0 on the 3rd edge after the write; busy = 1.
REQ-037 Raise snd_ack 5 cycles later and drop it after 4 more -> audio_irq_n = 1 the cycle after the ack; IDLE after the ack falls; busy = 0.
REQ-038 Five bg writes 0x01..0x05 back-to-back with snd_ack low (FIFO_DEPTH = 4) -> 0x01 is popped, 0x02..0x05 are queued, fifo_full = 1, no overflow; a 6th write sets err_flags[0]; sequenced output order is 0x01..0x05.
REQ-039 sfx writes idx 3 data 1, then idx 7 data 1, then idx 3 data 0 -> sfx_port = 0x08, then 0x88, then 0x80.
REQ-040 With DKONG_SND_ACK_TIMEOUT_EN and ACK_TIMEOUT = 16, bg write with no ack -> audio_irq_n returns to 1 exactly 16 cycles into WAIT_ACK and err_flags = 2'b10.
REQ-041 Assert rst_n low during WAIT_ACK -> audio_irq_n = 1 and bg_port = 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/dkong_sound_cmd_seq.sv
// Donkey Kong sound command sequencer.
// Main-CPU writes latch sfx/subsfx bits directly. Background commands go into a
// small FIFO, and a handshake FSM hands them to the sound CPU one at a time
// using audio_irq_n and snd_ack.
// Optional feature: define DKONG_SND_ACK_TIMEOUT_EN to abort a handshake when
// snd_ack does not arrive within ACK_TIMEOUT cycles.
module dkong_sound_cmd_seq #(
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 65535
) (
   input  logic       masterclk,
   input  logic       rst_n,
   input  logic       cpu_wr,
   input  logic [1:0] io_sel,
   input  logic [2:0] io_idx,
   input  logic [7:0] cpu_din,
   input  logic       snd_ack,
   output logic [4:0] bg_port,
   output logic [7:0] sfx_port,
   output logic       subsfx_port,
   output logic       audio_irq_n,
   output logic       fifo_full,
   output logic       busy,
   output logic [1:0] err_flags
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ASSERT,
      S_WAIT_ACK,
      S_WAIT_REL
   } state_t;

   state_t          r_state, w_nxt;
   logic [4:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_cnt;
   logic [4:0]      r_bg;
   logic [7:0]      r_sfx;
   logic            r_sub;
   logic            r_ovf;
   logic            w_req, w_full, w_empty, w_pop, w_push, w_ovf, w_tmo, w_tmo_err;
   logic [4:0]      w_push_data;

   // A bg write queues new data; an irq write with bit0 set re-queues whatever
   // is currently presented on bg_port (a resend).
   assign w_req       = cpu_wr && ((io_sel == 2'b00) || ((io_sel == 2'b10) && cpu_din[0]));
   assign w_push_data = (io_sel == 2'b00) ? cpu_din[4:0] : r_bg;
   assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
   assign w_empty     = (r_cnt == '0);
   // LOAD is only entered with a non-empty queue and nothing else pops, so the
   // pop never underflows.
   assign w_pop       = (r_state == S_LOAD);
   // A pop in the same cycle frees a slot, so a push into a full queue is
   // still accepted then.
   assign w_push      = w_req && (!w_full || w_pop);
   assign w_ovf       = w_req && w_full && !w_pop;

   // Queue storage; contents need no reset, occupancy is tracked by r_cnt.
   always_ff @(posedge masterclk) begin
      if (w_push) r_mem[r_wptr] <= w_push_data;
   end

   // Queue pointers, occupancy and sticky overflow flag.
   always_ff @(posedge masterclk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (w_ovf) r_ovf <= 1'b1;
      end
   end

   // Direct latches and the presented bg command, which changes only in LOAD.
   always_ff @(posedge masterclk or negedge rst_n) begin
      if (!rst_n) begin
         r_bg  <= '0;
         r_sfx <= '0;
         r_sub <= 1'b0;
      end else begin
         if (w_pop) r_bg <= r_mem[r_rptr];
         if (cpu_wr && (io_sel == 2'b01)) r_sfx[io_idx] <= cpu_din[0];
         if (cpu_wr && (io_sel == 2'b11)) r_sub <= cpu_din[0];
      end
   end

`ifdef DKONG_SND_ACK_TIMEOUT_EN
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   logic [TW-1:0] r_tcnt;
   logic          r_tmo_err;

   // Wait-for-ack timer: cleared in ASSERT, counts each WAIT_ACK cycle without
   // an ack; the last count aborts the handshake.
   always_ff @(posedge masterclk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt    <= '0;
         r_tmo_err <= 1'b0;
      end else begin
         if (r_state == S_ASSERT) r_tcnt <= '0;
         else if ((r_state == S_WAIT_ACK) && !snd_ack) r_tcnt <= r_tcnt + TW'(1);
         if (w_tmo) r_tmo_err <= 1'b1;
      end
   end

   assign w_tmo     = (r_state == S_WAIT_ACK) && !snd_ack && (r_tcnt == TW'(ACK_TIMEOUT - 1));
   assign w_tmo_err = r_tmo_err;
`else
   // No timer: WAIT_ACK waits forever. ACK_TIMEOUT is referenced only to keep
   // the parameter meaningful in both builds; the term is constant false.
   assign w_tmo     = 1'b0 & (ACK_TIMEOUT == 0);
   assign w_tmo_err = 1'b0;
`endif

   // Handshake state register.
   always_ff @(posedge masterclk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   // Handshake next-state; snd_ack is ignored outside WAIT_ACK/WAIT_REL.
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:     if (!w_empty) w_nxt = S_LOAD;
         S_LOAD:     w_nxt = S_ASSERT;
         S_ASSERT:   w_nxt = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (snd_ack)    w_nxt = S_WAIT_REL;
            else if (w_tmo) w_nxt = S_IDLE;
         end
         S_WAIT_REL: if (!snd_ack) w_nxt = S_IDLE;
         default:    w_nxt = S_IDLE;
      endcase
   end

   // Interrupt decoded from the state register, so async reset releases it
   // immediately and it rises the cycle after ack is seen.
   assign audio_irq_n = !((r_state == S_ASSERT) || (r_state == S_WAIT_ACK));
   assign bg_port     = r_bg;
   assign sfx_port    = r_sfx;
   assign subsfx_port = r_sub;
   assign fifo_full   = w_full;
   assign busy        = (r_state != S_IDLE) || !w_empty;
   assign err_flags   = {w_tmo_err, r_ovf};

endmodule
